mesi_isc_snoop_seq: RTL and testbench

MESI_ISC_SNOOP_SEQ -- requirements
Module: mesi_isc_snoop_seq

---
 rtl/mesi_isc_snoop_seq.sv | 140 ++++++++++++++
 tb/tb_mesi_isc_snoop_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesi_isc_snoop_seq.sv
// rtl/mesi_isc_snoop_seq.sv - snoop sequencer: broadcast FIFO head -> per-port snoop, then enable originator
module mesi_isc_snoop_seq #(
    parameter int CBUS_CMD_WIDTH   = 3,
    parameter int ADDR_WIDTH       = 32,
    parameter int BROAD_TYPE_WIDTH = 2,
    parameter int ACK_TIMEOUT      = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        broad_valid_i,
    input  logic [BROAD_TYPE_WIDTH-1:0] broad_type_i,
    input  logic [1:0]                  broad_cpu_id_i,
    input  logic [ADDR_WIDTH-1:0]       broad_addr_i,
    output logic                        broad_pop_o,
    input  logic                        cbus_ack3_i,
    input  logic                        cbus_ack2_i,
    input  logic                        cbus_ack1_i,
    input  logic                        cbus_ack0_i,
    output logic [CBUS_CMD_WIDTH-1:0]   cbus_cmd3_o,
    output logic [CBUS_CMD_WIDTH-1:0]   cbus_cmd2_o,
    output logic [CBUS_CMD_WIDTH-1:0]   cbus_cmd1_o,
    output logic [CBUS_CMD_WIDTH-1:0]   cbus_cmd0_o,
    output logic [ADDR_WIDTH-1:0]       cbus_addr_o,
    output logic                        busy_o,
    output logic                        err_type_o,
    output logic                        err_timeout_o
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CBUS_CMD_WIDTH-1:0] CMD_NOP      = '0;
    localparam logic [CBUS_CMD_WIDTH-1:0] CMD_WR_SNOOP = CBUS_CMD_WIDTH'(1);
    localparam logic [CBUS_CMD_WIDTH-1:0] CMD_RD_SNOOP = CBUS_CMD_WIDTH'(2);
    localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_WR    = CBUS_CMD_WIDTH'(3);
    localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_RD    = CBUS_CMD_WIDTH'(4);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SNOOP,
        ST_ENABLE
    } state_t;

    state_t                    state_q;
    logic [3:0]                pending_q;
    logic [3:0]                pending_d;
    logic [1:0]                cpu_q;
    logic                      rd_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [CBUS_CMD_WIDTH-1:0] cmd_q [4];

    logic [3:0]                ack;
    logic                      type_wr;
    logic                      type_rd;
    logic [CBUS_CMD_WIDTH-1:0] snoop_cmd;

    assign ack       = {cbus_ack3_i, cbus_ack2_i, cbus_ack1_i, cbus_ack0_i};
    // Acks on ports that are not pending simply fall out of the mask.
    assign pending_d = pending_q & ~ack;
    assign type_wr   = (broad_type_i == BROAD_TYPE_WIDTH'(1));
    assign type_rd   = (broad_type_i == BROAD_TYPE_WIDTH'(2));
    assign snoop_cmd = type_rd ? CMD_RD_SNOOP : CMD_WR_SNOOP;

    assign cbus_cmd0_o = cmd_q[0];
    assign cbus_cmd1_o = cmd_q[1];
    assign cbus_cmd2_o = cmd_q[2];
    assign cbus_cmd3_o = cmd_q[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pending_q     <= '0;
            cpu_q         <= '0;
            rd_q          <= 1'b0;
            cnt_q         <= '0;
            cbus_addr_o   <= '0;
            broad_pop_o   <= 1'b0;
            busy_o        <= 1'b0;
            err_type_o    <= 1'b0;
            err_timeout_o <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cmd_q[i] <= CMD_NOP;
            end
        end else begin
            broad_pop_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cbus_addr_o <= '0;
                    // The head is still the popped entry during the pop cycle, so skip it.
                    if (broad_valid_i && !broad_pop_o) begin
                        cbus_addr_o <= broad_addr_i;
                        cpu_q       <= broad_cpu_id_i;
                        rd_q        <= type_rd;
                        if (type_wr || type_rd) begin
                            state_q <= ST_SNOOP;
                            busy_o  <= 1'b1;
                            cnt_q   <= '0;
                            for (int i = 0; i < 4; i++) begin
                                pending_q[i] <= (2'(i) != broad_cpu_id_i);
                                cmd_q[i]     <= (2'(i) != broad_cpu_id_i) ? snoop_cmd : CMD_NOP;
                            end
                        end else begin
                            broad_pop_o <= 1'b1;
                            err_type_o  <= 1'b1;
                        end
                    end
                end
                ST_SNOOP, ST_ENABLE: begin
                    if (cnt_q != CNT_W'(ACK_TIMEOUT)) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                        err_timeout_o <= 1'b1;
                    end
                    if (state_q == ST_SNOOP) begin
                        pending_q <= pending_d;
                        for (int i = 0; i < 4; i++) begin
                            if (pending_q[i] && ack[i]) begin
                                cmd_q[i] <= CMD_NOP;
                            end
                        end
                        if (pending_d == 4'b0000) begin
                            state_q      <= ST_ENABLE;
                            cnt_q        <= '0;
                            cmd_q[cpu_q] <= rd_q ? CMD_EN_RD : CMD_EN_WR;
                        end
                    end else if (ack[cpu_q]) begin
                        cmd_q[cpu_q] <= CMD_NOP;
                        broad_pop_o  <= 1'b1;
                        busy_o       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mesi_isc_snoop_seq.sv
// tb/tb_mesi_isc_snoop_seq.sv - vector table, directed corner sequences and randomized model comparison
module tb_mesi_isc_snoop_seq;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        broad_valid_i;
    logic [1:0]  broad_type_i;
    logic [1:0]  broad_cpu_id_i;
    logic [31:0] broad_addr_i;
    logic        broad_pop_o;
    logic [3:0]  ack;
    logic [2:0]  cmd3, cmd2, cmd1, cmd0;
    logic [31:0] cbus_addr_o;
    logic        busy_o, err_type_o, err_timeout_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mesi_isc_snoop_seq #(.ACK_TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .broad_valid_i  (broad_valid_i),
        .broad_type_i   (broad_type_i),
        .broad_cpu_id_i (broad_cpu_id_i),
        .broad_addr_i   (broad_addr_i),
        .broad_pop_o    (broad_pop_o),
        .cbus_ack3_i    (ack[3]),
        .cbus_ack2_i    (ack[2]),
        .cbus_ack1_i    (ack[1]),
        .cbus_ack0_i    (ack[0]),
        .cbus_cmd3_o    (cmd3),
        .cbus_cmd2_o    (cmd2),
        .cbus_cmd1_o    (cmd1),
        .cbus_cmd0_o    (cmd0),
        .cbus_addr_o    (cbus_addr_o),
        .busy_o         (busy_o),
        .err_type_o     (err_type_o),
        .err_timeout_o  (err_timeout_o)
    );

    typedef struct {
        logic        r;
        logic        v;
        logic [1:0]  ty;
        logic [1:0]  cpu;
        logic [31:0] a;
        logic [3:0]  ak;
        logic [15:0] ecmd;
        logic        epop;
        logic        ebusy;
        logic        eet;
        logic        eeto;
        logic [31:0] eaddr;
    } vec_t;

    typedef struct {
        logic [1:0]  ty;
        logic [1:0]  cpu;
        logic [31:0] a;
    } ent_t;

    vec_t tbl [18];
    ent_t fifo [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic v, input logic [1:0] ty, input logic [1:0] cpu,
                         input logic [31:0] a, input logic [3:0] ak);
        rst = r; broad_valid_i = v; broad_type_i = ty; broad_cpu_id_i = cpu; broad_addr_i = a; ack = ak;
    endtask

    function automatic vec_t mk(input logic r, input logic v, input logic [1:0] ty, input logic [1:0] cpu,
                                input logic [31:0] a, input logic [3:0] ak, input logic [15:0] ec,
                                input logic ep, input logic eb, input logic eet, input logic eeto,
                                input logic [31:0] ea);
        vec_t t;
        t.r = r; t.v = v; t.ty = ty; t.cpu = cpu; t.a = a; t.ak = ak;
        t.ecmd = ec; t.epop = ep; t.ebusy = eb; t.eet = eet; t.eeto = eeto; t.eaddr = ea;
        return t;
    endfunction

    function automatic logic [15:0] cmd_vec();
        return {1'b0, cmd3, 1'b0, cmd2, 1'b0, cmd1, 1'b0, cmd0};
    endfunction

    function automatic logic [2:0] dut_cmd(input int p);
        case (p)
            0: return cmd0;
            1: return cmd1;
            2: return cmd2;
            default: return cmd3;
        endcase
    endfunction

    // Reference: phase 0 idle, 1 waiting for snoop acks, 2 waiting for originator ack.
    int         m_phase;
    bit  [3:0]  m_wait;
    int         m_orig;
    bit         m_rd;
    bit  [31:0] m_addr;
    bit         m_pop, m_et, m_eto;
    int         m_cyc;

    task automatic model_step(input logic r, input logic v, input logic [1:0] ty, input logic [1:0] cpu,
                              input logic [31:0] a, input logic [3:0] ak);
        bit pop_now;
        pop_now = m_pop;
        if (r) begin
            m_phase = 0; m_wait = '0; m_addr = '0; m_pop = 0; m_et = 0; m_eto = 0; m_cyc = 0;
            return;
        end
        m_pop = 0;
        if (m_phase == 0) begin
            m_addr = '0;
            if (v && !pop_now) begin
                m_addr = a;
                if (ty == 2'd1 || ty == 2'd2) begin
                    m_phase = 1; m_rd = (ty == 2'd2); m_orig = int'(cpu); m_cyc = 0;
                    m_wait = 4'hF; m_wait[cpu] = 1'b0;
                end else begin
                    m_pop = 1; m_et = 1;
                end
            end
        end else begin
            if (m_cyc < TMO) m_cyc++;
            if (m_cyc == TMO) m_eto = 1;
            if (m_phase == 1) begin
                m_wait = m_wait & ~ak;
                if (m_wait == 4'h0) begin
                    m_phase = 2; m_cyc = 0;
                end
            end else if (ak[m_orig]) begin
                m_phase = 0; m_pop = 1;
            end
        end
    endtask

    function automatic logic [2:0] exp_cmd(input int p);
        if (m_phase == 1 && m_wait[p]) return m_rd ? 3'd2 : 3'd1;
        if (m_phase == 2 && p == m_orig) return m_rd ? 3'd4 : 3'd3;
        return 3'd0;
    endfunction

    task automatic compare_model();
        for (int p = 0; p < 4; p++) begin
            check($sformatf("rnd_cmd%0d", p), 32'(dut_cmd(p)), 32'(exp_cmd(p)));
        end
        check("rnd_pop", 32'(broad_pop_o), 32'(m_pop));
        check("rnd_busy", 32'(busy_o), 32'(m_phase != 0));
        check("rnd_addr", cbus_addr_o, m_addr);
        check("rnd_err_type", 32'(err_type_o), 32'(m_et));
        check("rnd_err_timeout", 32'(err_timeout_o), 32'(m_eto));
    endtask

    initial begin
        ent_t head;
        logic r;

        tbl[0]  = mk(1'b1, 1'b0, 2'd0, 2'd0, 32'h0,  4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tbl[1]  = mk(1'b0, 1'b1, 2'd1, 2'd0, 32'h1,  4'h0, 16'h1110, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1);
        tbl[2]  = mk(1'b0, 1'b1, 2'd1, 2'd0, 32'h1,  4'h0, 16'h1110, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1);
        tbl[3]  = mk(1'b0, 1'b1, 2'd1, 2'd0, 32'h1,  4'hE, 16'h0003, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1);
        tbl[4]  = mk(1'b0, 1'b1, 2'd1, 2'd0, 32'h1,  4'h1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1);
        tbl[5]  = mk(1'b0, 1'b1, 2'd2, 2'd2, 32'h8,  4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tbl[6]  = mk(1'b0, 1'b1, 2'd2, 2'd2, 32'h8,  4'h0, 16'h2022, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8);
        tbl[7]  = mk(1'b0, 1'b1, 2'd2, 2'd2, 32'h8,  4'h8, 16'h0022, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8);
        tbl[8]  = mk(1'b0, 1'b1, 2'd2, 2'd2, 32'h8,  4'h0, 16'h0022, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8);
        tbl[9]  = mk(1'b0, 1'b1, 2'd2, 2'd2, 32'h8,  4'h1, 16'h0020, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8);
        tbl[10] = mk(1'b0, 1'b1, 2'd2, 2'd2, 32'h8,  4'h4, 16'h0020, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8);
        tbl[11] = mk(1'b0, 1'b1, 2'd2, 2'd2, 32'h8,  4'h2, 16'h0400, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8);
        tbl[12] = mk(1'b0, 1'b1, 2'd2, 2'd2, 32'h8,  4'h4, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8);
        tbl[13] = mk(1'b1, 1'b0, 2'd0, 2'd0, 32'h0,  4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tbl[14] = mk(1'b0, 1'b1, 2'd3, 2'd1, 32'h33, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h33);
        tbl[15] = mk(1'b0, 1'b1, 2'd1, 2'd3, 32'h44, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        tbl[16] = mk(1'b0, 1'b1, 2'd1, 2'd3, 32'h44, 4'h0, 16'h0111, 1'b0, 1'b1, 1'b1, 1'b0, 32'h44);
        tbl[17] = mk(1'b1, 1'b0, 2'd0, 2'd0, 32'h0,  4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        drive(1'b1, 1'b0, 2'd0, 2'd0, 32'h0, 4'h0);
        tick();

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].ty, tbl[i].cpu, tbl[i].a, tbl[i].ak);
            tick();
            check($sformatf("vec%0d_cmd", i), 32'(cmd_vec()), 32'(tbl[i].ecmd));
            check($sformatf("vec%0d_pop", i), 32'(broad_pop_o), 32'(tbl[i].epop));
            check($sformatf("vec%0d_busy", i), 32'(busy_o), 32'(tbl[i].ebusy));
            check($sformatf("vec%0d_err_type", i), 32'(err_type_o), 32'(tbl[i].eet));
            check($sformatf("vec%0d_err_timeout", i), 32'(err_timeout_o), 32'(tbl[i].eeto));
            check($sformatf("vec%0d_addr", i), cbus_addr_o, tbl[i].eaddr);
        end

        // Withheld ack on port 1: timeout after four snoop cycles, transaction still completes.
        drive(1'b0, 1'b1, 2'd1, 2'd0, 32'h10, 4'h0);
        tick();
        check("to_cmd_start", 32'(cmd_vec()), 32'h1110);
        ack = 4'hC;
        tick();
        ack = 4'h0;
        tick();
        tick();
        check("to_before", 32'(err_timeout_o), 32'd0);
        tick();
        check("to_set", 32'(err_timeout_o), 32'd1);
        check("to_still_snoop", 32'(cmd_vec()), 32'h0010);
        ack = 4'h2;
        tick();
        check("to_enable", 32'(cmd_vec()), 32'h0003);
        ack = 4'h1;
        tick();
        check("to_pop", 32'(broad_pop_o), 32'd1);
        check("to_sticky", 32'(err_timeout_o), 32'd1);
        drive(1'b0, 1'b0, 2'd0, 2'd0, 32'h0, 4'h0);
        tick();
        check("to_pop_once", 32'(broad_pop_o), 32'd0);

        // Reset in ENABLE abandons without pop; same entry replays afterwards.
        drive(1'b1, 1'b0, 2'd0, 2'd0, 32'h0, 4'h0);
        tick();
        drive(1'b0, 1'b1, 2'd2, 2'd1, 32'h20, 4'h0);
        tick();
        ack = 4'hD;
        tick();
        check("rs_enable", 32'(cmd_vec()), 32'h0040);
        rst = 1'b1; ack = 4'h0;
        tick();
        check("rs_cmd", 32'(cmd_vec()), 32'h0);
        check("rs_pop", 32'(broad_pop_o), 32'd0);
        check("rs_busy", 32'(busy_o), 32'd0);
        check("rs_addr", cbus_addr_o, 32'h0);
        rst = 1'b0;
        tick();
        check("rs_replay", 32'(cmd_vec()), 32'h2202);
        check("rs_replay_addr", cbus_addr_o, 32'h20);
        ack = 4'hD;
        tick();
        ack = 4'h2;
        tick();
        check("rs_done_pop", 32'(broad_pop_o), 32'd1);
        drive(1'b0, 1'b0, 2'd0, 2'd0, 32'h0, 4'h0);
        tick();

        // Randomized traffic against the reference model.
        drive(1'b1, 1'b0, 2'd0, 2'd0, 32'h0, 4'h0);
        model_step(1'b1, 1'b0, 2'd0, 2'd0, 32'h0, 4'h0);
        tick();
        compare_model();
        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(0, 99) == 0);
            if (fifo.size() < 4 && $urandom_range(0, 2) == 0) begin
                ent_t e;
                int   t;
                t = $urandom_range(0, 9);
                e.ty  = (t == 0) ? 2'd0 : (t == 1) ? 2'd3 : (t < 6) ? 2'd1 : 2'd2;
                e.cpu = 2'($urandom_range(0, 3));
                e.a   = $urandom;
                fifo.push_back(e);
            end
            if (fifo.size() > 0) head = fifo[0];
            else begin
                head.ty = 2'd0; head.cpu = 2'd0; head.a = 32'h0;
            end
            drive(r, fifo.size() > 0, head.ty, head.cpu, head.a, 4'($urandom & $urandom));
            model_step(rst, broad_valid_i, broad_type_i, broad_cpu_id_i, broad_addr_i, ack);
            tick();
            compare_model();
            if (broad_pop_o && fifo.size() > 0) void'(fifo.pop_front());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
